// File: rtl/uart_word_rx_fifo_pkg.sv
// uart_word_rx_fifo_pkg: shared constants, byte-order type and lane helper for the UART word receiver
package uart_word_rx_fifo_pkg;
    localparam int BYTE_W = 8;
    localparam int DEFAULT_CLK_PER_HALF_BIT = 434;
    typedef enum logic {BO_MSB_FIRST, BO_LSB_FIRST} byte_order_e;
    function automatic int lane_of(input int idx, input int nbytes, input byte_order_e bo);
        return (bo == BO_LSB_FIRST) ? idx : nbytes - 1 - idx;
    endfunction
endpackage

// File: rtl/uart_word_rx_fifo_if.sv
// uart_word_rx_fifo_if: valid/ready word stream between the receiver FIFO (master) and its consumer (slave)
//  data  : word payload, driven by master
//  valid : data holds an unconsumed word, driven by master
//  ready : consumer accepts data this cycle, driven by slave
interface uart_word_rx_fifo_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;
    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_word_rx_fifo_rx.sv
// uart_word_rx_fifo_rx: 8N1 UART byte receiver with one-cycle valid_rec strobe
//  clk, rstn : clock, asynchronous active-low reset
//  rx        : serial input, idle high
//  data_rec  : received byte, updated with valid_rec
//  valid_rec : one-cycle strobe when a byte with a good stop bit arrives
module uart_word_rx_fifo_rx
    import uart_word_rx_fifo_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = DEFAULT_CLK_PER_HALF_BIT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rx,
    output logic [BYTE_W-1:0] data_rec,
    output logic              valid_rec
);
    localparam int CW = $clog2(2 * CLK_PER_HALF_BIT);
    localparam logic [CW-1:0] HALF_END = CW'(CLK_PER_HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(2 * CLK_PER_HALF_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        bit_q;
    logic [BYTE_W-1:0] sr_q;
    logic [1:0]        sync_q;
    logic              rx_s;

    assign rx_s = sync_q[1];

    // Start edge is confirmed at mid start bit; every later sample lands mid-bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q    <= 2'b11;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            sr_q      <= '0;
            data_rec  <= '0;
            valid_rec <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rx};
            valid_rec <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF_END) begin
                        state_q <= rx_s ? S_IDLE : S_DATA;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == BIT_END) begin
                        cnt_q <= '0;
                        sr_q  <= {rx_s, sr_q[BYTE_W-1:1]};
                        bit_q <= bit_q + 1'b1;
                        if (bit_q == 3'd7) state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == BIT_END) begin
                        state_q   <= S_IDLE;
                        cnt_q     <= '0;
                        valid_rec <= rx_s;
                        data_rec  <= sr_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/uart_word_rx_fifo.sv
// uart_word_rx_fifo: assembles UART bytes into words, buffers them in a FIFO and streams them out
//  clk, rstn   : clock, asynchronous active-low reset
//  UART_RX     : serial input, idle high
//  flush       : sync clear of FIFO, partial word and output register
//  clr_err     : sync clear of sticky overflow/timeout_err
//  stream      : master side of the registered valid/ready word stream
//  count       : FIFO occupancy, excluding the output register
//  overflow    : sticky, a complete word was dropped
//  timeout_err : sticky, a partial word was discarded by timeout
module uart_word_rx_fifo
    import uart_word_rx_fifo_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = DEFAULT_CLK_PER_HALF_BIT,
    parameter int WORD_BYTES       = 4,
    parameter int DEPTH            = 128,
    parameter bit LSB_FIRST        = 1'b1,
    parameter int IDLE_TIMEOUT     = 0
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     UART_RX,
    input  logic                     flush,
    input  logic                     clr_err,
    uart_word_rx_fifo_if.master      stream,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     timeout_err
);
    localparam int W  = BYTE_W * WORD_BYTES;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int TW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam byte_order_e ORDER = byte_order_e'(LSB_FIRST);

    logic [BYTE_W-1:0] byte_rec;
    logic              valid_rec;

    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  asm_q, asm_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [TW-1:0] idle_q, idle_d;
    logic [W-1:0]  data_q, data_d;
    logic          valid_q, valid_d;
    logic          overflow_q, overflow_d;
    logic          timeout_q, timeout_d;

    logic [W-1:0]  mem [DEPTH];
    logic [W-1:0]  word_in;
    logic          last, got, full, empty, pop, push, drop, timeout;

    uart_word_rx_fifo_rx #(
        .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
    ) u_rx (
        .clk      (clk),
        .rstn     (rstn),
        .rx       (UART_RX),
        .data_rec (byte_rec),
        .valid_rec(valid_rec)
    );

    always_comb begin
        word_in = asm_q;
        word_in[BYTE_W * lane_of(int'(idx_q), WORD_BYTES, ORDER) +: BYTE_W] = byte_rec;
        last  = (int'(idx_q) == WORD_BYTES - 1);
        got   = valid_rec && !flush;
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty = (wr_ptr_q == rd_ptr_q);
        pop   = !flush && !empty && (!valid_q || stream.ready);
        // A pop in the same cycle frees the slot the push needs.
        push  = got && last && (!full || pop);
        drop  = got && last && !push;
        // An arriving byte always beats an expiring idle count.
        timeout = (IDLE_TIMEOUT > 0) && !valid_rec && (idx_q != '0) && (idle_q == TW'(IDLE_TIMEOUT - 1));
        idx_d = flush ? '0 : got ? (last ? '0 : idx_q + 1'b1) : timeout ? '0 : idx_q;
        asm_d = (flush || timeout) ? '0 : got ? (last ? '0 : word_in) : asm_q;
        idle_d = (IDLE_TIMEOUT == 0 || flush || valid_rec || timeout || idx_q == '0) ? '0 : idle_q + 1'b1;
        wr_ptr_d = flush ? rd_ptr_q : wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        data_d  = flush ? '0 : pop ? mem[rd_ptr_q[AW-1:0]] : data_q;
        valid_d = flush ? 1'b0 : pop ? 1'b1 : (stream.ready ? 1'b0 : valid_q);
        overflow_d = drop || (overflow_q && !clr_err);
        timeout_d  = timeout || (timeout_q && !clr_err);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= word_in;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_q      <= '0;
            asm_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            idle_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            asm_q      <= asm_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            idle_q     <= idle_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
        end
    end

    assign stream.data  = data_q;
    assign stream.valid = valid_q;
    assign count        = wr_ptr_q - rd_ptr_q;
    assign overflow     = overflow_q;
    assign timeout_err  = timeout_q;
endmodule

// File: tb/tb_uart_word_rx_fifo.sv
// tb_uart_word_rx_fifo: directed scoreboard bench for the UART word receiver FIFO
module tb_uart_word_rx_fifo;
    localparam int H     = 4;
    localparam int DEPTH = 4;
    localparam int TO    = 1000;

    logic clk = 1'b0;
    logic rstn, uart_rx, flush, clr_err;
    logic [2:0] a_count, b_count;
    logic a_ovf, a_to, b_ovf, b_to;

    uart_word_rx_fifo_if #(.DATA_W(32)) a_if ();
    uart_word_rx_fifo_if #(.DATA_W(32)) b_if ();

    always #5 clk = ~clk;

    uart_word_rx_fifo #(
        .CLK_PER_HALF_BIT(H), .WORD_BYTES(4), .DEPTH(DEPTH), .LSB_FIRST(1'b1), .IDLE_TIMEOUT(TO)
    ) dut_a (
        .clk(clk), .rstn(rstn), .UART_RX(uart_rx), .flush(flush), .clr_err(clr_err),
        .stream(a_if), .count(a_count), .overflow(a_ovf), .timeout_err(a_to)
    );

    uart_word_rx_fifo #(
        .CLK_PER_HALF_BIT(H), .WORD_BYTES(4), .DEPTH(DEPTH), .LSB_FIRST(1'b0), .IDLE_TIMEOUT(TO)
    ) dut_b (
        .clk(clk), .rstn(rstn), .UART_RX(uart_rx), .flush(1'b0), .clr_err(1'b0),
        .stream(b_if), .count(b_count), .overflow(b_ovf), .timeout_err(b_to)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int vcyc     = 0;
    bit done;
    logic [31:0] exp_q[$];
    logic [31:0] b_got[$];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_rx = 1'b0;
        tick(2 * H);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(2 * H);
        end
        uart_rx = 1'b1;
        tick(2 * H);
    endtask

    task automatic send_word(input logic [31:0] w, input bit keep);
        if (keep) exp_q.push_back(w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (a_if.valid) vcyc++;
            if (a_if.valid && a_if.ready) begin
                n_checks++;
                assert (exp_q.size() > 0 && a_if.data === exp_q[0]) else begin
                    n_fail++;
                    $error("FAIL a_word observed=%0h expected=%0h", a_if.data,
                           (exp_q.size() > 0) ? exp_q[0] : 32'hx);
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (b_if.valid && b_if.ready) b_got.push_back(b_if.data);
        end
    end

    initial begin
        rstn = 1'b0; uart_rx = 1'b1; flush = 1'b0; clr_err = 1'b0;
        a_if.ready = 1'b1; b_if.ready = 1'b1;
        tick(3);
        chk("rst_data", a_if.data, 0);
        chk("rst_valid", a_if.valid, 0);
        chk("rst_count", a_count, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_to", a_to, 0);
        rstn = 1'b1;
        tick(2);

        vcyc = 0;
        send_word(32'h44332211, 1'b1);
        tick(5);
        chk("t1_drained", exp_q.size(), 0);
        chk("t1_valid_cycles", vcyc, 1);
        chk("t1_count", a_count, 0);
        chk("t2_b_words", b_got.size(), 1);
        chk("t2_b_word", (b_got.size() > 0) ? b_got[0] : 32'hx, 32'h11223344);

        a_if.ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            send_word(32'h10203040 + k, k < 5);
            if (k == 4) begin
                chk("t3_count_w4", a_count, 4);
                chk("t3_ovf_w4", a_ovf, 0);
            end
        end
        tick(2);
        chk("t3_valid_held", a_if.valid, 1);
        chk("t3_data_w0", a_if.data, 32'h10203040);
        chk("t3_count", a_count, 4);
        chk("t3_ovf", a_ovf, 1);
        a_if.ready = 1'b1;
        tick(12);
        chk("t3_drained", exp_q.size(), 0);
        chk("t3_count_end", a_count, 0);
        chk("t3_valid_end", a_if.valid, 0);

        send_byte(8'h55);
        send_byte(8'h66);
        tick(900);
        chk("t4_no_early_to", a_to, 0);
        tick(200);
        chk("t4_to", a_to, 1);
        chk("t4_valid", a_if.valid, 0);
        send_word(32'hDDCCBBAA, 1'b1);
        tick(5);
        chk("t4_drained", exp_q.size(), 0);

        a_if.ready = 1'b0;
        for (int k = 0; k < 4; k++) send_word(32'hC0DE0000 + k, 1'b0);
        tick(2);
        chk("t5_count_pre", a_count, 3);
        chk("t5_valid_pre", a_if.valid, 1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        chk("t5_flush_valid", a_if.valid, 0);
        chk("t5_flush_count", a_count, 0);
        chk("t5_ovf_sticky", a_ovf, 1);
        chk("t5_to_sticky", a_to, 1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("t5_clr_ovf", a_ovf, 0);
        chk("t5_clr_to", a_to, 0);
        a_if.ready = 1'b1;
        tick(10);
        send_word(32'h0BADF00D, 1'b1);
        tick(5);
        chk("t5_post_flush", exp_q.size(), 0);

        a_if.ready = 1'b0;
        send_word(32'h12345678, 1'b0);
        send_word(32'h9ABCDEF0, 1'b0);
        tick(2);
        chk("t5_pre_rst_count", a_count, 1);
        uart_rx = 1'b0;
        tick(20);
        #2 rstn = 1'b0;
        #1;
        chk("t5_arst_data", a_if.data, 0);
        chk("t5_arst_valid", a_if.valid, 0);
        chk("t5_arst_count", a_count, 0);
        uart_rx = 1'b1;
        tick(3);
        rstn = 1'b1;
        tick(40);

        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 3 * DEPTH; k++) send_word($urandom, 1'b1);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    a_if.ready = 1'($urandom_range(0, 1));
                    tick(1);
                end
            end
        join
        a_if.ready = 1'b1;
        tick(20);
        chk("t6_drained", exp_q.size(), 0);
        chk("t6_ovf", a_ovf, 0);
        chk("t6_count", a_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
